// File: rtl/screen_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : screen_mem_responder
// Description : Memory-side responder for the screen prefetch path. Serves
//               in-order reads from a 1-cycle-latency video RAM through a
//               small response FIFO. CPU writes share the RAM port and take
//               priority over reads.
//               Optional address checking: define SCREEN_MEM_ADDR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_mem_responder #(
    parameter int AW        = 19,
    parameter int DW        = 16,
    parameter int FD        = 3,
    parameter int MEM_WORDS = 8192
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_addr_vld,
    output logic          req_addr_gnt,
    input  logic [AW-1:0] req_addr,
    output logic          rsp_dat_vld,
    input  logic          rsp_dat_gnt,
    output logic [DW-1:0] rsp_dat,
    input  logic          cpu_wr_vld,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0] cpu_wr_dat,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdat,
    input  logic [DW-1:0] ram_rdat,
    output logic          addr_err
);

    localparam int          PW        = (FD > 2) ? $clog2(FD) : 1;
    localparam int          CW        = $clog2(FD + 1);
    localparam logic [AW:0] C_MEM_LIM = (AW + 1)'(MEM_WORDS);

    // FIFO storage and control state
    logic [DW-1:0] fifo_q [FD];
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          infl_q, infl_d;
    logic          zero_q, zero_d;   // in-flight read was out of range
    logic          err_q,  err_d;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_push_dat;
    logic          w_rd_oor;
    logic          w_wr_oor;

`ifdef SCREEN_MEM_ADDR_CHK_EN
    assign w_rd_oor = ({1'b0, req_addr}    >= C_MEM_LIM);
    assign w_wr_oor = ({1'b0, cpu_wr_addr} >= C_MEM_LIM);
`else
    logic w_unused_lim;
    assign w_rd_oor     = 1'b0;
    assign w_wr_oor     = 1'b0;
    assign w_unused_lim = ^C_MEM_LIM;
`endif

    // Grant depends only on registered occupancy and the CPU write strobe
    assign req_addr_gnt = !cpu_wr_vld &&
                          (({1'b0, cnt_q} + {{CW{1'b0}}, infl_q}) < (CW + 1)'(FD));
    assign w_accept     = req_addr_vld && req_addr_gnt;
    assign w_push       = infl_q;
    assign w_pop        = rsp_dat_vld && rsp_dat_gnt;
    assign w_push_dat   = zero_q ? '0 : ram_rdat;

    assign rsp_dat_vld  = (cnt_q != '0);
    assign rsp_dat      = rsp_dat_vld ? fifo_q[rptr_q] : '0;
    assign addr_err     = err_q;

    // RAM port mux: CPU write first, then an accepted in-range read
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wdat = '0;
        if (cpu_wr_vld) begin
            if (!w_wr_oor) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cpu_wr_addr;
                ram_wdat = cpu_wr_dat;
            end
        end else if (w_accept && !w_rd_oor) begin
            ram_en   = 1'b1;
            ram_addr = req_addr;
        end
    end

    // Next-state for occupancy, pointers, in-flight tracking and error flag
    always_comb begin
        cnt_d  = cnt_q + CW'(w_push) - CW'(w_pop);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_push) begin
            wptr_d = (wptr_q == PW'(FD - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (w_pop) begin
            rptr_d = (rptr_q == PW'(FD - 1)) ? '0 : rptr_q + 1'b1;
        end
        infl_d = w_accept;
        zero_d = w_accept && w_rd_oor;
        err_d  = err_q || (w_accept && w_rd_oor) || (cpu_wr_vld && w_wr_oor);
    end

    // Control registers; reset discards anything queued or in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            infl_q <= 1'b0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            infl_q <= infl_d;
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end

    // Capture returning RAM data at the write pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FD; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (w_push) begin
            fifo_q[wptr_q] <= w_push_dat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_screen_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_mem_responder
// Description : Self-checking bench for screen_mem_responder with a
//               synchronous RAM model and an in-order response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_mem_responder;

    localparam int AW        = 19;
    localparam int DW        = 16;
    localparam int FD        = 3;
    localparam int MEM_WORDS = 8192;

    logic          clk;
    logic          rstn;
    logic          req_addr_vld;
    logic          req_addr_gnt;
    logic [AW-1:0] req_addr;
    logic          rsp_dat_vld;
    logic          rsp_dat_gnt;
    logic [DW-1:0] rsp_dat;
    logic          cpu_wr_vld;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_dat;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat;
    logic [DW-1:0] ram_rdat;
    logic          addr_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] popped;

    screen_mem_responder #(
        .AW(AW), .DW(DW), .FD(FD), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_addr_vld(req_addr_vld), .req_addr_gnt(req_addr_gnt), .req_addr(req_addr),
        .rsp_dat_vld(rsp_dat_vld), .rsp_dat_gnt(rsp_dat_gnt), .rsp_dat(rsp_dat),
        .cpu_wr_vld(cpu_wr_vld), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_dat(cpu_wr_dat),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdat(ram_wdat),
        .ram_rdat(ram_rdat), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous video RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdat;
            else        ram_rdat <= ram_mem[ram_addr[7:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic in_range(input logic [AW-1:0] a);
`ifdef SCREEN_MEM_ADDR_CHK_EN
        return (a < MEM_WORDS);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (!in_range(a)) return '0;
        return ref_mem[a[7:0]];
    endfunction

    // Scoreboard: expectations pushed on accept, popped on response handshake
    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_dat_vld && rsp_dat_gnt) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_rsp: got 0x%0h expected no response", rsp_dat);
                end else begin
                    popped = exp_q.pop_front();
                    check("rsp_data", {16'h0, rsp_dat}, {16'h0, popped});
                end
            end
            if (req_addr_vld && req_addr_gnt) begin
                exp_q.push_back(exp_read(req_addr));
                check("no_overflow", {31'h0, exp_q.size() <= FD}, 32'h1);
            end
        end
        if (cpu_wr_vld && in_range(cpu_wr_addr)) ref_mem[cpu_wr_addr[7:0]] = cpu_wr_dat;
    end

    typedef struct {
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          g;
        logic          en;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          chk_wd;
    } vec_t;

    vec_t tbl [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_addr_vld = 1'b0;
        cpu_wr_vld   = 1'b0;
        repeat (n) step();
    endtask

    int grants;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 19'h0,  16'h0,    1'b0, 19'h0,  1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b1};
        tbl[1] = '{1'b0, 19'h0,  16'h0,    1'b1, 19'h21, 1'b1, 1'b1, 1'b0, 19'h21, 16'h0,    1'b0};
        tbl[2] = '{1'b1, 19'h22, 16'h5A5A, 1'b0, 19'h0,  1'b0, 1'b1, 1'b1, 19'h22, 16'h5A5A, 1'b1};
        tbl[3] = '{1'b1, 19'h23, 16'h1111, 1'b1, 19'h24, 1'b0, 1'b1, 1'b1, 19'h23, 16'h1111, 1'b1};
        tbl[4] = '{1'b0, 19'h0,  16'h0,    1'b1, 19'h22, 1'b1, 1'b1, 1'b0, 19'h22, 16'h0,    1'b0};
        tbl[5] = '{1'b0, 19'h0,  16'h0,    1'b0, 19'h30, 1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b1};

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 + 16'(i);
        end
        ram_mem[16'h10] = 16'hBEEF;
        ref_mem[16'h10] = 16'hBEEF;

        rstn = 1'b0; req_addr_vld = 1'b0; req_addr = '0; rsp_dat_gnt = 1'b1;
        cpu_wr_vld = 1'b0; cpu_wr_addr = '0; cpu_wr_dat = '0; ram_rdat = '0;

        // Reset values
        #2;
        check("rst_gnt", {31'h0, req_addr_gnt}, 32'h1);
        check("rst_rsp_vld", {31'h0, rsp_dat_vld}, 32'h0);
        check("rst_rsp_dat", {16'h0, rsp_dat}, 32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        cpu_wr_vld = 1'b1; cpu_wr_addr = 19'h40; cpu_wr_dat = 16'h4444;
        #1;
        check("rst_gnt_cpuwr", {31'h0, req_addr_gnt}, 32'h0);
        check("rst_ram_we_cpuwr", {31'h0, ram_en & ram_we}, 32'h1);
        @(negedge clk);
        step();
        cpu_wr_vld = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", {31'h0, req_addr_gnt}, 32'h1);

        // Table-driven RAM port and grant vectors
        for (int i = 0; i < 6; i++) begin
            step();
            cpu_wr_vld = tbl[i].cw; cpu_wr_addr = tbl[i].ca; cpu_wr_dat = tbl[i].cd;
            req_addr_vld = tbl[i].rv; req_addr = tbl[i].ra;
            @(negedge clk);
            check("tbl_gnt", {31'h0, req_addr_gnt}, {31'h0, tbl[i].g});
            check("tbl_en", {31'h0, ram_en}, {31'h0, tbl[i].en});
            check("tbl_we", {31'h0, ram_we}, {31'h0, tbl[i].we});
            check("tbl_addr", {13'h0, ram_addr}, {13'h0, tbl[i].a});
            if (tbl[i].chk_wd) check("tbl_wdat", {16'h0, ram_wdat}, {16'h0, tbl[i].wd});
        end
        idle(6);

        // Single-request latency
        step();
        req_addr_vld = 1'b1; req_addr = 19'h10;
        @(negedge clk);
        check("lat_gnt", {31'h0, req_addr_gnt}, 32'h1);
        check("lat_ram_en", {31'h0, ram_en}, 32'h1);
        check("lat_ram_addr", {13'h0, ram_addr}, 32'h10);
        step();
        req_addr_vld = 1'b0;
        @(negedge clk);
        check("lat_vld_n1", {31'h0, rsp_dat_vld}, 32'h0);
        step();
        @(negedge clk);
        check("lat_vld_n2", {31'h0, rsp_dat_vld}, 32'h1);
        check("lat_dat_n2", {16'h0, rsp_dat}, 32'hBEEF);
        idle(4);

        // Eight back-to-back requests, full throughput
        for (int k = 0; k <= 10; k++) begin
            step();
            req_addr_vld = (k < 8);
            req_addr = 19'(k);
            @(negedge clk);
            if (k < 8) check("b2b_gnt", {31'h0, req_addr_gnt}, 32'h1);
            if (k >= 2 && k < 10) check("b2b_vld", {31'h0, rsp_dat_vld}, 32'h1);
            if (k == 10) check("b2b_vld_end", {31'h0, rsp_dat_vld}, 32'h0);
        end
        idle(4);

        // Backpressure: FD grants, stable head, one pop gives one more grant
        rsp_dat_gnt = 1'b0;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            req_addr_vld = 1'b1; req_addr = 19'h30 + 19'(k);
            @(negedge clk);
            if (req_addr_gnt) grants++;
            if (k >= 2) check("bp_head", {15'h0, rsp_dat_vld, rsp_dat}, {15'h0, 1'b1, 16'hA030});
        end
        check("bp_grants", grants, 3);
        step();
        rsp_dat_gnt = 1'b1;
        @(negedge clk);
        check("bp_full_gnt", {31'h0, req_addr_gnt}, 32'h0);
        step();
        rsp_dat_gnt = 1'b0;
        grants = 0;
        for (int k = 0; k < 4; k++) begin
            req_addr = 19'h38 + 19'(k);
            @(negedge clk);
            if (req_addr_gnt) grants++;
            check("bp_head2", {16'h0, rsp_dat}, 32'hA031);
            step();
        end
        check("bp_grants_after_pop", grants, 1);
        req_addr_vld = 1'b0;
        rsp_dat_gnt = 1'b1;
        idle(8);

        // CPU write blocks a same-address read; next read sees new data
        step();
        cpu_wr_vld = 1'b1; cpu_wr_addr = 19'h5; cpu_wr_dat = 16'h1234;
        req_addr_vld = 1'b1; req_addr = 19'h5;
        @(negedge clk);
        check("wr_blocks_gnt", {31'h0, req_addr_gnt}, 32'h0);
        step();
        cpu_wr_vld = 1'b0;
        @(negedge clk);
        check("wr_then_gnt", {31'h0, req_addr_gnt}, 32'h1);
        step();
        req_addr_vld = 1'b0;
        step();
        @(negedge clk);
        check("wr_then_rd_dat", {15'h0, rsp_dat_vld, rsp_dat}, {15'h0, 1'b1, 16'h1234});
        idle(4);

`ifdef SCREEN_MEM_ADDR_CHK_EN
        // Out-of-range accesses
        step();
        req_addr_vld = 1'b1; req_addr = 19'(MEM_WORDS);
        @(negedge clk);
        check("oor_gnt", {31'h0, req_addr_gnt}, 32'h1);
        check("oor_ram_en", {31'h0, ram_en}, 32'h0);
        step();
        req_addr_vld = 1'b0;
        @(negedge clk);
        check("oor_err_set", {31'h0, addr_err}, 32'h1);
        step();
        @(negedge clk);
        check("oor_rsp", {15'h0, rsp_dat_vld, rsp_dat}, {15'h0, 1'b1, 16'h0});
        step();
        cpu_wr_vld = 1'b1; cpu_wr_addr = 19'(MEM_WORDS + 1); cpu_wr_dat = 16'hDEAD;
        @(negedge clk);
        check("oor_wr_en", {31'h0, ram_en}, 32'h0);
        idle(5);
        check("oor_err_sticky", {31'h0, addr_err}, 32'h1);
        rstn = 1'b0;
        #1;
        check("oor_err_clr", {31'h0, addr_err}, 32'h0);
        rstn = 1'b1;
        idle(2);
`endif

        // Reset mid-operation: 2 queued, 1 in flight
        rsp_dat_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            req_addr_vld = 1'b1; req_addr = 19'h50 + 19'(k);
        end
        step();
        req_addr_vld = 1'b0;
        rstn = 1'b0;
        rsp_dat_gnt = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_vld", {31'h0, rsp_dat_vld}, 32'h0);
        check("midrst_gnt", {31'h0, req_addr_gnt}, 32'h1);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("midrst_no_stale", {31'h0, rsp_dat_vld}, 32'h0);
            step();
        end

        // Final drain and error flag
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        check("queue_drained", exp_q.size(), 0);
        check("final_addr_err", {31'h0, addr_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
